pc_next_unit: RTL

//   Parametrised program-counter unit: the sequential successor of the PC adder.

---
 rtl/pc_next_unit_if.sv | 37 +++
 rtl/pc_next_unit.sv | 118 +++++++++++
 2 files changed

// File: rtl/pc_next_unit_if.sv
// Fetch-side bundle for the program-counter unit: redirect requests in,
// current PC and return-address-stack status out.
interface pc_next_unit_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  // No valid/ready handshake here: every request field is sampled on each
  // rising clk edge where stall is low, and every status field is valid
  // for the whole cycle after that edge.
  logic             stall;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic             call;
  logic [WIDTH-1:0] jump_target;
  logic             ret;

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic [CW-1:0]    ras_count;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output stall, branch_taken, branch_target, jump, call, jump_target, ret,
    input  pc, pc_plus, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, call, jump_target, ret,
    output pc, pc_plus, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_next_unit.sv
// Program-counter register with next-PC selection and a circular
// return-address stack that feeds call/return targets.
module pc_next_unit #(
  parameter int               WIDTH        = 32,
  parameter int               INC          = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               DEPTH        = 8
) (
  input  logic          clk,
  input  logic          rst,
  pc_next_unit_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] pc_next;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    ptr_next;
  logic [PW-1:0]    top_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_next;
  logic             ovf_q;
  logic             ovf_next;
  logic             unf_q;
  logic             unf_next;
  logic             empty;
  logic             full;
  logic             wr_en;
  logic [PW-1:0]    wr_addr;
  logic [WIDTH-1:0] ras [DEPTH];

  assign pc_plus = pc_q + WIDTH'(INC);
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  // ptr names the next free slot, so the top of stack sits one below it.
  assign top_ptr = ptr_q - PW'(1);

  always_comb begin
    pc_next    = pc_q;
    ptr_next   = ptr_q;
    count_next = count_q;
    ovf_next   = 1'b0;
    unf_next   = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = ptr_q;
    if (!bus.stall) begin
      pc_next = pc_plus;
      if (bus.ret && bus.call) begin
        wr_en = 1'b1;
        if (!empty) begin
          // Return and re-call at once: swap the top entry in place.
          pc_next = ras[top_ptr];
          wr_addr = top_ptr;
        end else begin
          wr_addr    = ptr_q;
          ptr_next   = ptr_q + PW'(1);
          count_next = CW'(1);
          unf_next   = 1'b1;
        end
      end else if (bus.ret) begin
        if (!empty) begin
          pc_next    = ras[top_ptr];
          ptr_next   = top_ptr;
          count_next = count_q - CW'(1);
        end else begin
          unf_next = 1'b1;
        end
      end else if (bus.call) begin
        pc_next  = bus.jump_target;
        wr_en    = 1'b1;
        wr_addr  = ptr_q;
        ptr_next = ptr_q + PW'(1);
        if (full) begin
          ovf_next = 1'b1;
        end else begin
          count_next = count_q + CW'(1);
        end
      end else if (bus.jump) begin
        pc_next = bus.jump_target;
      end else if (bus.branch_taken) begin
        pc_next = bus.branch_target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_next;
      ptr_q   <= ptr_next;
      count_q <= count_next;
      ovf_q   <= ovf_next;
      unf_q   <= unf_next;
    end
  end

  // Stack contents are don't-care after reset, so the storage has no reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      ras[wr_addr] <= pc_plus;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_plus       = pc_plus;
  assign bus.ras_count     = count_q;
  assign bus.ras_empty     = empty;
  assign bus.ras_full      = full;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;
endmodule
